// File: rtl/event_encoder_pkg.sv
// Shared types and helpers for the event encoder: FSM states, code type
// and the one-hot expansion of a code.
package event_encoder_pkg;

    localparam int N_EV = 4;

    typedef logic [1:0] code_t;

    typedef enum logic {
        IDLE,
        OFFER
    } state_e;

    function automatic logic [N_EV-1:0] code_onehot(input code_t c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin request picker: first set bit of req searching from last+1,
// wrapping modulo four.
module rr_pick
    import event_encoder_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       any,
    output logic [1:0] idx
);

    code_t cand;

    always_comb begin
        any  = 1'b0;
        idx  = 2'b00;
        cand = 2'b00;
        // Offsets 1..4 so that 'last' itself is searched last.
        for (int k = 1; k <= N_EV; k++) begin
            cand = last + code_t'(k);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/event_encoder.sv
// Captures rising edges on four event lines as pending bits and streams them
// out as 2-bit codes over a valid/ready handshake in round-robin order.
module event_encoder
    import event_encoder_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             D0,
    input  logic             D1,
    input  logic             D2,
    input  logic             D3,
    input  logic             E,
    output logic [1:0]       A,
    output logic             V,
    input  logic             R,
    output logic [CNT_W-1:0] OVF
);

    localparam logic [CNT_W+2:0] OVF_MAX = {3'b000, {CNT_W{1'b1}}};

    state_e           state_q, state_d;
    logic [3:0]       prev_q, prev_d;
    logic [3:0]       pend_q, pend_d;
    code_t            last_q, last_d;
    code_t            a_q, a_d;
    logic [CNT_W-1:0] ovf_q, ovf_d;

    logic [3:0]       d_vec;
    logic [3:0]       ev;
    logic             xfer;
    logic [3:0]       xfer_bits;
    logic [3:0]       drops;
    logic [2:0]       n_drop;
    logic [CNT_W+2:0] ovf_sum;
    logic [3:0]       mask;
    logic [3:0]       pick_req;
    code_t            pick_last;
    logic             pick_any;
    code_t            pick_idx;

    // Edge capture, pending set/clear and the saturating drop counter.
    always_comb begin
        d_vec     = {D3, D2, D1, D0};
        ev        = d_vec & ~prev_q & {4{E}};
        xfer      = (state_q == OFFER) && R;
        xfer_bits = xfer ? code_onehot(a_q) : 4'b0000;
        drops     = ev & pend_q & ~xfer_bits;
        n_drop    = {2'b00, drops[0]} + {2'b00, drops[1]}
                  + {2'b00, drops[2]} + {2'b00, drops[3]};
        ovf_sum   = {3'b000, ovf_q} + {{CNT_W{1'b0}}, n_drop};
        ovf_d     = (ovf_sum > OVF_MAX) ? {CNT_W{1'b1}} : ovf_sum[CNT_W-1:0];
        prev_d    = d_vec;
        // A new event on the bit being transferred keeps it pending.
        pend_d    = (pend_q & ~xfer_bits) | ev;
        mask      = pend_q & ~code_onehot(a_q);
        pick_req  = (state_q == OFFER) ? mask : pend_q;
        pick_last = (state_q == OFFER) ? a_q : last_q;
    end

    rr_pick u_pick (
        .req  (pick_req),
        .last (pick_last),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    a_d     = pick_idx;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (R) begin
                    last_d = a_q;
                    if (pick_any) begin
                        a_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prev_q  <= 4'b0000;
            pend_q  <= 4'b0000;
            last_q  <= 2'd3;
            a_q     <= 2'd0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            a_q     <= a_d;
            ovf_q   <= ovf_d;
        end
    end

    assign A   = a_q;
    assign V   = (state_q == OFFER);
    assign OVF = ovf_q;

endmodule

// File: tb/tb_event_encoder.sv
// Self-checking bench for event_encoder: directed scenarios plus a random
// run compared against a behavioural model of the pending/round-robin rules.
module tb_event_encoder;

    localparam int CNT_W   = 8;
    localparam int OVF_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [3:0]       dv;
    logic             E;
    logic             R;
    logic [1:0]       A;
    logic             V;
    logic [CNT_W-1:0] OVF;

    int n_cmp;
    int n_bad;

    bit [3:0] mpend;
    bit [3:0] mprev;
    int       mlast;
    bit       mv;
    int       ma;
    int       movf;

    event_encoder #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .D0    (dv[0]),
        .D1    (dv[1]),
        .D2    (dv[2]),
        .D3    (dv[3]),
        .E     (E),
        .A     (A),
        .V     (V),
        .R     (R),
        .OVF   (OVF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input bit [3:0] req, input int from);
        int found;
        found = -1;
        for (int k = 1; k <= 4; k++) begin
            if (found < 0 && req[(from + k) % 4]) found = (from + k) % 4;
        end
        return found;
    endfunction

    task automatic model_reset();
        mpend = '0;
        mprev = '0;
        mlast = 3;
        mv    = 1'b0;
        ma    = 0;
        movf  = 0;
    endtask

    task automatic model_step();
        bit [3:0] ev;
        bit [3:0] old;
        bit [3:0] rem;
        bit       xf;
        int       xi;
        int       p;
        old = mpend;
        xf  = mv && R;
        xi  = ma;
        for (int i = 0; i < 4; i++) ev[i] = dv[i] && !mprev[i] && E;
        for (int i = 0; i < 4; i++) begin
            if (ev[i] && old[i] && !(xf && xi == i))
                movf = (movf < OVF_MAX) ? movf + 1 : OVF_MAX;
        end
        mpend = old;
        if (xf) mpend[xi] = 1'b0;
        mpend = mpend | ev;
        if (!mv) begin
            p = pick(old, mlast);
            if (p >= 0) begin
                ma = p;
                mv = 1'b1;
            end
        end else if (xf) begin
            mlast = xi;
            rem = old;
            rem[xi] = 1'b0;
            p = pick(rem, xi);
            if (p >= 0) ma = p;
            else        mv = 1'b0;
        end
        mprev = dv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic do_reset();
        dv    = 4'b0000;
        E     = 1'b1;
        R     = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (V !== 1'b0 || A !== 2'd0 || OVF !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_values: V=%0b A=%0d OVF=%0d, required V=0 A=0 OVF=0", V, A, OVF);
        end
    endtask

    task automatic test_single_pulse();
        do_reset();
        R  = 1'b1;
        dv = 4'b0100;
        tick();
        n_cmp++;
        if (V !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL pulse_latency: V=%0b, required V=0", V);
        end
        dv = 4'b0000;
        tick();
        n_cmp++;
        if (V !== 1'b1 || A !== 2'd2) begin
            n_bad++;
            $display("[TB] FAIL pulse_offer: V=%0b A=%0d, required V=1 A=2", V, A);
        end
        tick();
        n_cmp++;
        if (V !== 1'b0 || OVF !== '0) begin
            n_bad++;
            $display("[TB] FAIL pulse_done: V=%0b OVF=%0d, required V=0 OVF=0", V, OVF);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        R  = 1'b1;
        dv = 4'b1111;
        tick();
        dv = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (V !== 1'b1 || A !== 2'(i)) begin
                n_bad++;
                $display("[TB] FAIL simul_code%0d: V=%0b A=%0d, required V=1 A=%0d", i, V, A, i);
            end
        end
        tick();
        n_cmp++;
        if (V !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL simul_end: V=%0b, required V=0", V);
        end
    endtask

    task automatic test_hold_stable();
        do_reset();
        dv = 4'b1010;
        tick();
        dv = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (V !== 1'b1 || A !== 2'd1) begin
                n_bad++;
                $display("[TB] FAIL hold_cycle%0d: V=%0b A=%0d, required V=1 A=1", i, V, A);
            end
        end
        R = 1'b1;
        tick();
        n_cmp++;
        if (V !== 1'b1 || A !== 2'd3) begin
            n_bad++;
            $display("[TB] FAIL hold_b2b: V=%0b A=%0d, required V=1 A=3", V, A);
        end
        tick();
        n_cmp++;
        if (V !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL hold_end: V=%0b, required V=0", V);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        repeat (3) begin
            dv = 4'b0001;
            tick();
            dv = 4'b0000;
            tick();
        end
        n_cmp++;
        if (OVF !== CNT_W'(2) || V !== 1'b1 || A !== 2'd0) begin
            n_bad++;
            $display("[TB] FAIL ovf_three_edges: OVF=%0d V=%0b A=%0d, required OVF=2 V=1 A=0", OVF, V, A);
        end
        repeat (300) begin
            dv = 4'b0001;
            tick();
            dv = 4'b0000;
            tick();
        end
        n_cmp++;
        if (OVF !== CNT_W'(OVF_MAX)) begin
            n_bad++;
            $display("[TB] FAIL ovf_saturate: OVF=%0d, required %0d", OVF, OVF_MAX);
        end
    endtask

    task automatic test_enable_and_reset();
        do_reset();
        E = 1'b0;
        R = 1'b1;
        for (int i = 0; i < 10; i++) begin
            dv = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            tick();
            n_cmp++;
            if (V !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL enable_block%0d: V=%0b, required V=0", i, V);
            end
        end
        E  = 1'b1;
        R  = 1'b0;
        dv = 4'b0000;
        tick();
        dv = 4'b0010;
        tick();
        tick();
        n_cmp++;
        if (V !== 1'b1 || A !== 2'd1) begin
            n_bad++;
            $display("[TB] FAIL enable_offer: V=%0b A=%0d, required V=1 A=1", V, A);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (V !== 1'b0 || A !== 2'd0 || OVF !== '0) begin
            n_bad++;
            $display("[TB] FAIL async_reset: V=%0b A=%0d OVF=%0d, required 0 0 0", V, A, OVF);
        end
        dv = 4'b0000;
        R  = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (V !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL no_stale%0d: V=%0b A=%0d, required V=0", i, V, A);
            end
        end
    endtask

    task automatic test_same_edge();
        do_reset();
        dv = 4'b0100;
        tick();
        dv = 4'b0000;
        tick();
        n_cmp++;
        if (V !== 1'b1 || A !== 2'd2) begin
            n_bad++;
            $display("[TB] FAIL same_first: V=%0b A=%0d, required V=1 A=2", V, A);
        end
        dv = 4'b0100;
        R  = 1'b1;
        tick();
        n_cmp++;
        if (V !== 1'b0 || OVF !== '0) begin
            n_bad++;
            $display("[TB] FAIL same_xfer: V=%0b OVF=%0d, required V=0 OVF=0", V, OVF);
        end
        tick();
        n_cmp++;
        if (V !== 1'b1 || A !== 2'd2) begin
            n_bad++;
            $display("[TB] FAIL same_reoffer: V=%0b A=%0d, required V=1 A=2", V, A);
        end
        tick();
        n_cmp++;
        if (V !== 1'b0 || OVF !== '0) begin
            n_bad++;
            $display("[TB] FAIL same_end: V=%0b OVF=%0d, required V=0 OVF=0", V, OVF);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            dv = 4'($urandom_range(0, 15));
            E  = ($urandom_range(0, 3) != 0);
            R  = ($urandom_range(0, 2) != 0);
            tick();
            n_cmp++;
            if (V !== mv || (mv && A !== 2'(ma)) || OVF !== CNT_W'(movf)) begin
                n_bad++;
                $display("[TB] FAIL random_cycle%0d: V=%0b A=%0d OVF=%0d, required V=%0b A=%0d OVF=%0d",
                         i, V, A, OVF, mv, ma, movf);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        dv    = 4'b0000;
        E     = 1'b1;
        R     = 1'b0;
        model_reset();
        test_reset();
        test_single_pulse();
        test_simultaneous();
        test_hold_stable();
        test_overflow();
        test_enable_and_reset();
        test_same_edge();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
